// File: rtl/cpu_pkg.sv
// Shared core definitions: exception/boot vectors, instruction width,
// the PC increment rule (kernel bit [31] is sticky) and the fetch FSM states.
package cpu_pkg;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] START_VEC = 32'h0000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HOLD} fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Only the low 31 bits advance; the kernel bit never changes on increment.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction
endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/response, redirect and
// hold controls from the core, and the valid/ready instruction port to ID.
//   master : the fetch unit
//   slave  : memory + core environment
interface fetch_prefetch_unit_if;
  import cpu_pkg::*;
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [31:0]        redirect_target;
  logic               hold;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [31:0]        id_pc;
  logic [31:0]        id_pc4;
  logic               fetch_err;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4, fetch_err,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_target,
           hold, id_ready
  );
  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc4, fetch_err,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_target,
           hold, id_ready
  );
endinterface

// File: rtl/fetch_prefetch_unit_fifo.sv
// fetch_fifo: DEPTH x {pc, instr} circular queue.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_flush        : empties the queue at the next edge (wins over push/pop)
//   i_push, i_data : enqueue one entry
//   i_pop          : drop the head; push+pop on a full queue is legal
//   o_head         : current head entry (undefined when o_count==0)
//   o_count        : number of valid entries
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  fetch_entry_t                 i_data,
  output fetch_entry_t                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wr, r_rd;
  logic [CW-1:0]  r_count;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage with prefetch queue.
//   clk   : core clock
//   reset : async active-low reset
//   bus   : fetch_prefetch_unit_if.master (imem req/gnt/rvalid, redirect,
//           hold, id valid/ready/instr/pc/pc4, fetch_err)
// Keeps up to MAX_OUTSTANDING requests in flight, never more than the queue
// can absorb, and discards responses that belong to a pre-redirect path.
// A response arriving on an empty queue is forwarded straight to ID.
module fetch_prefetch_unit
  import cpu_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000
) (
  input logic                   clk,
  input logic                   reset,
  fetch_prefetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);

  fetch_state_e  r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;   // PC of the next response that will be kept
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_discard;
  logic          r_fetch_err;

  logic [CW-1:0] w_count, w_live, w_out_nxt;
  logic          w_redir, w_req, w_issue, w_rsp, w_enq;
  logic          w_empty, w_byp, w_vld, w_fire, w_push, w_pop;
  fetch_entry_t  w_in, w_fifo_head, w_head;

  assign w_redir = bus.redirect_valid && (r_state != ST_BOOT);
  assign w_live  = r_out - r_discard;  // in-flight responses that will land in the queue
  assign w_req   = (r_state == ST_RUN) && !w_redir &&
                   (({1'b0, w_count} + {1'b0, w_live}) < (CW+1)'(DEPTH)) &&
                   (r_out < CW'(MAX_OUTSTANDING));
  assign w_issue = w_req && bus.imem_gnt;
  assign w_rsp   = bus.imem_rvalid && (r_out != '0);
  assign w_enq   = w_rsp && (r_discard == '0) && !w_redir;
  assign w_out_nxt = r_out + CW'(w_issue) - CW'(w_rsp);

  assign w_in.pc    = r_resp_pc;
  assign w_in.instr = bus.imem_rdata;

  // Empty-queue bypass gives redirect -> id_valid in two cycles.
  assign w_empty = (w_count == '0);
  assign w_byp   = w_empty && w_enq;
  assign w_head  = w_empty ? w_in : w_fifo_head;
  assign w_vld   = !w_empty || w_byp;
  assign w_fire  = w_vld && bus.id_ready && (r_state != ST_HOLD) && !w_redir;
  assign w_push  = w_enq && !(w_byp && w_fire);
  assign w_pop   = w_fire && !w_empty;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_flush (w_redir),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in),
    .o_head  (w_fifo_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_BOOT;
      r_fetch_pc  <= RESET_VECTOR;
      r_resp_pc   <= RESET_VECTOR;
      r_out       <= '0;
      r_discard   <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN:  if (bus.hold)  r_state <= ST_HOLD;
        ST_HOLD: if (!bus.hold) r_state <= ST_RUN;
        default: r_state <= ST_BOOT;
      endcase
      r_out       <= w_out_nxt;
      r_fetch_err <= bus.imem_rvalid && (r_out == '0);
      if (w_redir) begin
        // Everything still in flight after this cycle is wrong-path.
        r_discard  <= w_out_nxt;
        r_fetch_pc <= bus.redirect_target & ~32'd3;
        r_resp_pc  <= bus.redirect_target & ~32'd3;
      end else begin
        if (w_rsp && (r_discard != '0)) r_discard <= r_discard - CW'(1);
        if (w_issue) r_fetch_pc <= pc_inc(r_fetch_pc);
        if (w_enq)   r_resp_pc  <= pc_inc(r_resp_pc);
      end
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.id_valid  = w_vld;
  assign bus.id_pc     = w_vld ? w_head.pc : 32'h0;
  assign bus.id_instr  = w_vld ? w_head.instr : '0;
  assign bus.id_pc4    = w_vld ? pc_inc(w_head.pc) : 32'h0;
  assign bus.fetch_err = r_fetch_err;
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
module tb_fetch_prefetch_unit;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RV    = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_prefetch_unit_if bus();

  fetch_prefetch_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_VECTOR(RV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mem_q[$];   // addresses granted, awaiting memory response
  logic [31:0] exp_q[$];   // scoreboard: PCs expected at ID, in order
  logic [31:0] m_pc;       // model fetch PC
  bit          m_hold, m_hold_n, rsp_en, spur;
  bit          l_req, l_vld, l_fire, l_err, l_gnt;
  logic [31:0] l_pc, l_pc4, l_gaddr, ga0, ga1;

  typedef struct packed { logic [31:0] tgt, a0, a1; } vec_t;
  vec_t tbl [4];

  function automatic logic [31:0] m_inc(input logic [31:0] p);
    return {p[31], p[30:0] + 31'd4};
  endfunction
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hC0DE_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++; n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // One clock: drive memory response, sample at negedge, update models.
  task automatic step();
    logic [31:0] a, e;
    if (spur) begin
      bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; spur = 1'b0;
    end else if (rsp_en && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      bus.imem_rvalid = 1'b1; bus.imem_rdata = mem_f(a);
    end else begin
      bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    end
    @(negedge clk);
    l_req = bus.imem_req; l_vld = bus.id_valid; l_pc = bus.id_pc;
    l_pc4 = bus.id_pc4; l_err = bus.fetch_err; l_gnt = 1'b0;
    if (bus.redirect_valid) chk("req_during_redirect", 32'(l_req), 32'd0);
    if (m_hold) chk("req_during_hold", 32'(l_req), 32'd0);
    if (l_req && bus.imem_gnt) begin
      l_gnt = 1'b1; l_gaddr = bus.imem_addr;
      chk("imem_addr", bus.imem_addr, m_pc);
      mem_q.push_back(bus.imem_addr);
      exp_q.push_back(m_pc);
      m_pc = m_inc(m_pc);
    end
    l_fire = l_vld && bus.id_ready && !m_hold && !bus.redirect_valid;
    if (l_fire) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_output: got pc %h expected none", l_pc);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", l_pc, e);
        chk("id_instr", bus.id_instr, mem_f(e));
        chk("id_pc4", l_pc4, m_inc(e));
      end
    end
    if (bus.redirect_valid) begin
      exp_q.delete();
      m_pc = {bus.redirect_target[31:2], 2'b00};
    end
    m_hold_n = bus.hold;
    @(posedge clk); #1;
    m_hold = m_hold_n;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   32'(bus.imem_req),  32'd0);
    chk({tag, "_addr"},  bus.imem_addr,       RV);
    chk({tag, "_vld"},   32'(bus.id_valid),  32'd0);
    chk({tag, "_pc"},    bus.id_pc,           32'd0);
    chk({tag, "_instr"}, bus.id_instr,        32'd0);
    chk({tag, "_pc4"},   bus.id_pc4,          32'd0);
    chk({tag, "_err"},   32'(bus.fetch_err), 32'd0);
  endtask

  // Called at posedge+1 right after reset release with gnt/ready high.
  task automatic boot_seq(input string tag);
    for (int c = 0; c < 5; c++) begin
      step();
      if (c < 2) chk({tag, "_vld_early"}, 32'(l_vld), 32'd0);
      else begin
        chk({tag, "_vld"}, 32'(l_vld), 32'd1);
        chk({tag, "_pc"}, l_pc, RV + 32'(4 * (c - 2)));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int ng;
    tbl[0] = '{32'h7FFF_FFFC, 32'h7FFF_FFFC, 32'h0000_0000};
    tbl[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h8000_0000};
    tbl[2] = '{32'h8000_0006, 32'h8000_0004, 32'h8000_0008};
    tbl[3] = '{32'h1234_5673, 32'h1234_5670, 32'h1234_5674};

    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_target = '0; bus.hold = 1'b0;
    bus.id_ready = 1'b0; spur = 1'b0; rsp_en = 1'b1; m_hold = 1'b0; m_pc = RV;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");

    // 1: streaming from reset vector
    bus.imem_gnt = 1'b1; bus.id_ready = 1'b1; reset = 1'b1;
    boot_seq("t1");

    // 2: ID stalled -> queue fills to DEPTH, issue stops, nothing lost
    bus.id_ready = 1'b0;
    repeat (10) step();
    chk("t2_req_full", 32'(l_req), 32'd0);
    chk("t2_queued", 32'(exp_q.size()), 32'(DEPTH));
    bus.id_ready = 1'b1;
    repeat (8) step();

    // 3: redirect with MAX_OUTSTANDING in flight
    bus.imem_gnt = 1'b0;
    repeat (6) step();
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    rsp_en = 1'b0; bus.imem_gnt = 1'b1;
    repeat (4) step();
    chk("t3_inflight", 32'(mem_q.size()), 32'(MAXO));
    chk("t3_req_cap", 32'(l_req), 32'd0);
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h8000_0004; rsp_en = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (l_fire) found = 1'b1;
    end
    if (!found) timeout("t3_first_after_redirect");
    else begin
      chk("t3_pc", l_pc, 32'h8000_0004);
      chk("t3_pc4", l_pc4, 32'h8000_0008);
    end

    // 4: increment wrap vectors
    for (int v = 0; v < 4; v++) begin
      bus.redirect_valid = 1'b1; bus.redirect_target = tbl[v].tgt;
      step();
      bus.redirect_valid = 1'b0;
      ng = 0;
      for (int i = 0; i < 12 && ng < 2; i++) begin
        step();
        if (l_gnt) begin
          if (ng == 0) ga0 = l_gaddr; else ga1 = l_gaddr;
          ng++;
        end
      end
      if (ng < 2) timeout("t4_grants");
      else begin
        chk("t4_addr0", ga0, tbl[v].a0);
        chk("t4_addr1", ga1, tbl[v].a1);
      end
      repeat (3) step();
    end

    // 5: hold mid-stream
    repeat (4) step();
    bus.hold = 1'b1;
    repeat (5) step();
    chk("t5_vld_in_hold", 32'(l_vld), 32'd1);
    bus.hold = 1'b0;
    repeat (8) step();

    // spurious response
    bus.imem_gnt = 1'b0;
    repeat (6) step();
    spur = 1'b1;
    step();
    chk("spur_no_enq", 32'(l_vld), 32'd0);
    chk("spur_err_lat", 32'(l_err), 32'd0);
    step();
    chk("fetch_err_pulse", 32'(l_err), 32'd1);
    step();
    chk("fetch_err_clear", 32'(l_err), 32'd0);

    // 6: redirect coincident with rvalid + id_ready, then reset mid-burst
    bus.imem_gnt = 1'b1;
    repeat (4) step();
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h0000_0100;
    step();
    bus.redirect_valid = 1'b0;
    step();
    chk("t6_no_enq_after_redir", 32'(l_vld), 32'd0);
    repeat (3) step();
    #2 reset = 1'b0;
    #1 chk_reset("t6_reset");
    bus.imem_rvalid = 1'b0;
    mem_q.delete(); exp_q.delete(); m_pc = RV; m_hold = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    boot_seq("t6_boot");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
